// File: rtl/sram_axi_bridge.sv
// Bridges a single-outstanding SRAM-style core port onto AXI single-beat reads and writes.
// The fixed AXI fields (ids, len=0, burst, lock, cache, prot) are tied off by the parent.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [3:0]  sram_ben,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  ben_q;
    logic        wr_q;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [2:0]  size;

    always_comb begin
        case (ben_q)
            4'b1111:                            size = 3'd2;
            4'b0011, 4'b1100:                   size = 3'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
            default:                            size = 3'd2;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state_q)
            IDLE: begin
                sram_addr_ok = sram_req;
                if (sram_req) begin
                    state_d   = sram_wr ? AWW : AR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_d = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid) state_d = RESP;
            end
            AWW: begin
                // Each channel drops its valid independently once its own handshake lands.
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = B;
            end
            B: begin
                bready = 1'b1;
                if (bvalid) state_d = RESP;
            end
            RESP: begin
                sram_data_ok = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            sram_addr_ok = 1'b0;
            sram_data_ok = 1'b0;
            arvalid      = 1'b0;
            rready       = 1'b0;
            awvalid      = 1'b0;
            wvalid       = 1'b0;
            bready       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ben_q     <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (sram_addr_ok) begin
                addr_q  <= sram_addr;
                wdata_q <= sram_wdata;
                ben_q   <= sram_ben;
                wr_q    <= sram_wr;
                rdata_q <= '0;  // writes report zero read data
            end
            if (state_q == R && rvalid) rdata_q <= rdata;
        end
    end

    assign sram_rdata = rdata_q;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign arsize     = wr_q ? 3'd0 : size;
    assign awsize     = wr_q ? size : 3'd0;
    assign wdata      = wdata_q;
    assign wstrb      = ben_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave by hand, cycle by cycle.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_req, sram_wr;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, " valids"}, {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk({tag, " data_ok"}, sram_data_ok, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] ben,
                           input logic [31:0] d, input logic [2:0] sz);
        arready = 1; rvalid = 1; rdata = d;
        sram_req = 1; sram_wr = 0; sram_ben = ben; sram_addr = a; settle();
        chk("rd addr_ok", sram_addr_ok, 1);
        cyc(); sram_req = 0; settle();
        chk("rd arvalid", arvalid, 1);
        chk("rd araddr", araddr, a);
        chk("rd arsize", arsize, sz);
        cyc(); settle();
        chk("rd rready", rready, 1);
        cyc(); settle();
        chk("rd data_ok", sram_data_ok, 1);
        chk("rd rdata", sram_rdata, d);
        cyc(); settle();
        chk("rd done", sram_data_ok, 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] ben,
                            input logic [31:0] d, input logic [2:0] sz);
        awready = 1; wready = 1; bvalid = 1;
        sram_req = 1; sram_wr = 1; sram_ben = ben; sram_addr = a; sram_wdata = d; settle();
        chk("wr addr_ok", sram_addr_ok, 1);
        cyc(); sram_req = 0; settle();
        chk("wr aw/w valid", {awvalid, wvalid}, 2'b11);
        chk("wr awaddr", awaddr, a);
        chk("wr awsize", awsize, sz);
        chk("wr wstrb", wstrb, ben);
        chk("wr wdata", wdata, d);
        cyc(); settle();
        chk("wr bready", bready, 1);
        cyc(); settle();
        chk("wr data_ok", sram_data_ok, 1);
        chk("wr rdata zero", sram_rdata, 0);
        cyc(); settle();
        chk("wr done", sram_data_ok, 0);
    endtask

    initial begin
        rst = 1; sram_req = 1; sram_wr = 0; sram_ben = 4'hF;
        sram_addr = 32'h0; sram_wdata = 32'h0;
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;

        // Reset: request held high must not be acknowledged.
        cyc(); cyc(); settle();
        chk("rst addr_ok", sram_addr_ok, 0);
        idle_outs("rst");
        chk("rst rdata", sram_rdata, 0);
        chk("rst araddr", araddr, 0);
        sram_req = 0;
        cyc(); rst = 0;

        // Minimum-latency read.
        do_read(32'h1FC0_0000, 4'b1111, 32'h3C08_BFAF, 3'd2);

        // Write with awready delayed, wready immediate.
        awready = 0; wready = 1; bvalid = 1;
        sram_req = 1; sram_wr = 1; sram_ben = 4'b0011;
        sram_addr = 32'h0000_0100; sram_wdata = 32'h1234_5678; settle();
        chk("w46 addr_ok", sram_addr_ok, 1);
        cyc(); sram_req = 0; settle();
        chk("w46 c1 valids", {awvalid, wvalid}, 2'b11);
        chk("w46 awsize", awsize, 3'd1);
        chk("w46 wstrb", wstrb, 4'b0011);
        chk("w46 wdata", wdata, 32'h1234_5678);
        cyc(); settle();
        chk("w46 c2 valids", {awvalid, wvalid}, 2'b10);
        cyc(); settle();
        chk("w46 c3 valids", {awvalid, wvalid}, 2'b10);
        cyc(); awready = 1; settle();
        chk("w46 c4 valids", {awvalid, wvalid}, 2'b10);
        chk("w46 c4 bready", bready, 0);
        cyc(); awready = 0; settle();
        chk("w46 c5 awvalid", awvalid, 0);
        chk("w46 c5 bready", bready, 1);
        cyc(); settle();
        chk("w46 data_ok", sram_data_ok, 1);
        chk("w46 rdata", sram_rdata, 0);
        cyc(); settle();
        chk("w46 done", sram_data_ok, 0);

        // Size mapping and a zero-strobe write.
        do_read(32'h0000_0202, 4'b0100, 32'hAA, 3'd0);
        do_read(32'h0000_0302, 4'b1100, 32'hBBBB, 3'd1);
        do_read(32'h0000_0400, 4'b0101, 32'hCAFE_F00D, 3'd2);
        do_write(32'h0000_0500, 4'b0000, 32'hDEAD_BEEF, 3'd2);
        do_write(32'h0000_0601, 4'b0010, 32'h0000_5500, 3'd0);

        // Back-to-back reads with the request held high.
        arready = 1; rvalid = 1; rdata = 32'h1111_2222;
        sram_req = 1; sram_wr = 0; sram_ben = 4'hF; sram_addr = 32'h700; settle();
        chk("b2b addr_ok0", sram_addr_ok, 1);
        cyc(); settle();
        chk("b2b AR addr_ok", sram_addr_ok, 0);
        chk("b2b AR only", {arvalid, awvalid, wvalid}, 3'b100);
        cyc(); settle();
        chk("b2b R addr_ok", sram_addr_ok, 0);
        cyc(); settle();
        chk("b2b data_ok", sram_data_ok, 1);
        chk("b2b RESP addr_ok", sram_addr_ok, 0);
        cyc(); settle();
        chk("b2b addr_ok1", sram_addr_ok, 1);
        chk("b2b idle data_ok", sram_data_ok, 0);
        cyc(); sram_req = 0; settle();
        chk("b2b 2nd arvalid", arvalid, 1);
        cyc(); cyc(); settle();
        chk("b2b 2nd data_ok", sram_data_ok, 1);
        cyc();

        // rvalid withheld 10 cycles while the core address changes.
        arready = 1; rvalid = 0; rdata = 32'h5A5A_0001;
        sram_req = 1; sram_wr = 0; sram_ben = 4'hF; sram_addr = 32'h0000_0800; settle();
        chk("slow addr_ok", sram_addr_ok, 1);
        cyc(); sram_req = 0; sram_addr = 32'hFFFF_0000; settle();
        chk("slow araddr AR", araddr, 32'h0000_0800);
        for (int i = 0; i < 10; i++) begin
            cyc(); sram_addr = sram_addr + 32'h4; settle();
            chk("slow wait", {rready, sram_data_ok}, 2'b10);
        end
        chk("slow araddr R", araddr, 32'h0000_0800);
        rvalid = 1;
        cyc(); rvalid = 0; settle();
        chk("slow data_ok", sram_data_ok, 1);
        chk("slow rdata", sram_rdata, 32'h5A5A_0001);
        cyc(); settle();
        chk("slow single", sram_data_ok, 0);

        // Reset pulsed in R abandons the read.
        arready = 1; rvalid = 0;
        sram_req = 1; sram_wr = 0; sram_addr = 32'h0000_0900; settle();
        cyc(); sram_req = 0; cyc(); settle();
        chk("rstR rready", rready, 1);
        rst = 1;
        cyc(); rst = 0; settle();
        idle_outs("rstR post");
        chk("rstR rdata", sram_rdata, 0);
        chk("rstR araddr", araddr, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            idle_outs("rstR quiet");
        end
        do_read(32'h0000_0A00, 4'b1111, 32'h7777_8888, 3'd2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
